multibank_pingpong_buffer: RTL
==============================

Name: multibank_pingpong_buffer

Overview:
- Parametrised successor to the two-bank ping-pong dual-port RAM: N independent banks of NUM_WORDS x DWIDTH, organised as a ring.
- A producer fills one bank and commits it; a consumer reads committed banks in commit order and releases each when finished.
- Explicit handshakes, fill tracking and error flags replace the free-running toggle.
- Sits between accelerator compute stages: activation/weight staging, layer-to-layer double and triple buffering.

Parameters:
- DWIDTH, 60, data word width in bits.
- AWIDTH, 12, word address width within one bank.
- NUM_WORDS, 4096, words per bank; must satisfy NUM_WORDS <= 2^AWIDTH.
- NUM_BANKS, 2, number of banks; must be >= 2; non-power-of-two values allowed.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  write one word into the current write bank.
- wr_addr  in  AWIDTH  word address within the write bank.
- wr_data  in  DWIDTH  write data.
- wr_commit  in  1  current write bank is complete; hand it to the consumer.
- wr_ready  out  1  a free bank is available to the producer.
- rd_en  in  1  read one word from the current read bank.
- rd_addr  in  AWIDTH  word address within the read bank.
- rd_data  out  DWIDTH  read data.
- rd_data_valid  out  1  rd_data is updated this cycle.
- rd_release  in  1  consumer is done with the current read bank.
- rd_avail  out  1  at least one committed bank is waiting.
- fill_level  out  $clog2(NUM_BANKS+1)  number of committed, unreleased banks.
- err_overflow  out  1  sticky: wr_commit or wr_en was asserted while wr_ready=0.
- err_underflow  out  1  sticky: rd_release or rd_en was asserted while rd_avail=0.

Behaviour:
- Reset (reset low, asserted asynchronously) values:
  - wr_bank and rd_bank = 0.
  - fill_level = 0, wr_ready = 1, rd_avail = 0.
  - rd_data = 0, rd_data_valid = 0.
  - Both error flags = 0.
- Reset does not clear RAM contents. Reset mid-operation discards all committed banks.
- Status decode:
  - wr_ready = (fill_level < NUM_BANKS).
  - rd_avail = (fill_level != 0).
  - Both are decoded from registered state only; no combinational path from any input.
- Bank pointers:
  - Each pointer is $clog2(NUM_BANKS) bits, minimum 1.
  - Increment wraps explicitly: NUM_BANKS-1 -> 0. Do not rely on natural overflow.
- Write:
  - wr_en with wr_ready writes mem[wr_bank][wr_addr] at the edge.
  - wr_en with wr_ready=0 is dropped and sets err_overflow.
- Commit:
  - wr_commit with wr_ready advances wr_bank and increments fill_level.
  - wr_commit with wr_ready=0 is ignored and sets err_overflow.
  - wr_en and wr_commit in the same cycle: the word lands in the bank being committed.
- Read:
  - rd_en with rd_avail: rd_data = mem[rd_bank][rd_addr] one cycle later, with rd_data_valid high for that one cycle.
  - Otherwise rd_data holds its value, rd_data_valid = 0, and a read with rd_avail=0 sets err_underflow.
- Release:
  - rd_release with rd_avail advances rd_bank and decrements fill_level.
  - rd_release with rd_avail=0 is ignored and sets err_underflow.
  - rd_en and rd_release in the same cycle: the read uses the bank being released.
- Simultaneous accepted commit and release: both pointers advance and fill_level is unchanged.
- Release at fill_level = NUM_BANKS together with commit: the commit is rejected, because wr_ready is evaluated before the release takes effect.
- Bank hazard: the producer and consumer never address the same bank.
  - When fill_level = 0, wr_bank = rd_bank but reads are blocked.
  - When fill_level = NUM_BANKS, wr_bank = rd_bank but writes are blocked.
  - Therefore no read-during-write case exists.
- Address range: addresses >= NUM_WORDS are undefined. Verification must not drive them.
- Latency:
  - Commit to rd_avail: 1 cycle.
  - Release to wr_ready: 1 cycle.

Decomposition:
- Shared package:
  - BANK_W = max(1, $clog2(NUM_BANKS)).
  - FILL_W = $clog2(NUM_BANKS+1).
  - A next-bank wrap function.
- Sub-module bank_sdpram:
  - Simple dual-port RAM: one write port, one registered read port, NUM_WORDS x DWIDTH.
  - Instantiated NUM_BANKS times via generate; switchable to the hard dual_port_ram primitive.
  - Top-level read mux is selected by the registered rd_bank captured with rd_en.

Test Plan:
- Basic ping-pong (NUM_BANKS=2): write addr 0..3 = 0x10..0x13, commit. Expect rd_avail=1 after 1 cycle; reading addr 2 returns 0x12 one cycle later with rd_data_valid=1.
- Full: commit 2 banks without release. Expect fill_level=2, wr_ready=0. A third commit sets err_overflow=1 and fill_level stays 2.
- Simultaneous commit and release at fill_level=1: fill_level stays 1, both pointers advance. The next read returns data from the newly committed bank.
- Wrap with NUM_BANKS=3:
  - Commit/release 7 times, with distinct data per bank (bank k writes 0xA0+k at addr 5).
  - Read order returns 0xA0, 0xA1, 0xA2, 0xA0 ... and rd_bank wraps 2 -> 0.
- Underflow: rd_en or rd_release at reset state. Expect rd_data_valid=0, rd_data=0, err_underflow=1, fill_level=0.
- Async reset mid-stream: pull reset low between edges with fill_level=1. All outputs return to their reset values immediately; after reset, rd_avail=0 and wr_ready=1.

Source files
------------

// File: rtl/multibank_pingpong_buffer_pkg.sv
// Shared sizing helpers and ring-pointer arithmetic for the multi-bank ping-pong buffer.
package multibank_pingpong_buffer_pkg;

  // Smallest default bank count; also the floor for pointer width.
  localparam int unsigned MIN_BANKS = 2;

  function automatic int unsigned bank_width(int unsigned n);
    return (n <= MIN_BANKS) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned fill_width(int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Wrap is explicit so non-power-of-two rings never visit an unused index.
  function automatic int unsigned next_bank(int unsigned ptr, int unsigned n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/multibank_pingpong_buffer_bank_sdpram.sv
// One bank: simple dual-port RAM, single write port and a registered read port.
module multibank_pingpong_buffer_bank_sdpram #(
  parameter int unsigned DWIDTH    = 60,
  parameter int unsigned AWIDTH    = 12,
  parameter int unsigned NUM_WORDS = 4096
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data
);

  logic [DWIDTH-1:0] mem [NUM_WORDS];

  // No reset on the array or read register so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/multibank_pingpong_buffer.sv
// Ring of NUM_BANKS RAM banks: producer commits filled banks, consumer reads and releases them.
module multibank_pingpong_buffer
  import multibank_pingpong_buffer_pkg::*;
#(
  parameter int unsigned DWIDTH    = 60,
  parameter int unsigned AWIDTH    = 12,
  parameter int unsigned NUM_WORDS = 4096,
  parameter int unsigned NUM_BANKS = 2,
  localparam int unsigned FILL_W   = fill_width(NUM_BANKS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              wr_commit,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_data_valid,
  input  logic              rd_release,
  output logic              rd_avail,
  output logic [FILL_W-1:0] fill_level,
  output logic              err_overflow,
  output logic              err_underflow
);

  localparam int unsigned BANK_W = bank_width(NUM_BANKS);

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [BANK_W-1:0] rd_sel_q;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_ov_q, err_un_q;
  logic              rd_valid_q, rd_has_data_q;
  logic              wr_fire, commit_fire, rd_fire, release_fire;
  logic [DWIDTH-1:0] bank_rd [NUM_BANKS];

  // Status comes from registered fill only, so no input reaches wr_ready/rd_avail.
  assign wr_ready   = (fill_q < FILL_W'(NUM_BANKS));
  assign rd_avail   = (fill_q != '0);
  assign fill_level = fill_q;

  assign wr_fire      = wr_en & wr_ready;
  assign commit_fire  = wr_commit & wr_ready;
  assign rd_fire      = rd_en & rd_avail;
  assign release_fire = rd_release & rd_avail;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    fill_d    = fill_q;
    if (commit_fire) wr_bank_d = BANK_W'(next_bank(32'(wr_bank_q), NUM_BANKS));
    if (release_fire) rd_bank_d = BANK_W'(next_bank(32'(rd_bank_q), NUM_BANKS));
    case ({commit_fire, release_fire})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank_q     <= '0;
      rd_bank_q     <= '0;
      rd_sel_q      <= '0;
      fill_q        <= '0;
      err_ov_q      <= 1'b0;
      err_un_q      <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_has_data_q <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      fill_q     <= fill_d;
      err_ov_q   <= err_ov_q | ((wr_en | wr_commit) & ~wr_ready);
      err_un_q   <= err_un_q | ((rd_en | rd_release) & ~rd_avail);
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_sel_q      <= rd_bank_q;
        rd_has_data_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
    multibank_pingpong_buffer_bank_sdpram #(
      .DWIDTH   (DWIDTH),
      .AWIDTH   (AWIDTH),
      .NUM_WORDS(NUM_WORDS)
    ) u_bank (
      .clk    (clk),
      .wr_en  (wr_fire && (wr_bank_q == BANK_W'(i))),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .rd_en  (rd_fire && (rd_bank_q == BANK_W'(i))),
      .rd_addr(rd_addr),
      .rd_data(bank_rd[i])
    );
  end

  // Bank read registers are unreset; hide them until the first read after reset.
  assign rd_data       = rd_has_data_q ? bank_rd[rd_sel_q] : '0;
  assign rd_data_valid = rd_valid_q;
  assign err_overflow  = err_ov_q;
  assign err_underflow = err_un_q;

endmodule
